// File: rtl/layer_post_proc_if.sv
// Handshake/data bundle for layer_post_proc; res is present only when LAYER_POST_RES_EN is defined.
// data_e is taken on a clk edge only when in_ready and mode_in are both high; data_e_out is a
// one-cycle strobe and data_out holds until the next strobe; para_e writes one word per edge while mode_in is low.
interface layer_post_proc_if #(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4,
    parameter int PS_WIDTH    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PARA_WIDTH  = 8
);
    logic                                        mode_in;
    logic                                        para_e;
    logic [PARA_WIDTH-1:0]                       para_in;
    logic                                        para_done;
    logic                                        data_e;
    logic                                        in_ready;
    logic [CHANNEL_NUM*MACRO_NUM*PS_WIDTH-1:0]   data_in;
`ifdef LAYER_POST_RES_EN
    logic [CHANNEL_NUM*DATA_WIDTH-1:0]           res;
`endif
    logic                                        data_e_out;
    logic [CHANNEL_NUM*DATA_WIDTH-1:0]           data_out;
    logic                                        err_drop;

    modport master (
        output mode_in, para_e, para_in, data_e, data_in,
`ifdef LAYER_POST_RES_EN
               res,
`endif
        input  para_done, in_ready, data_e_out, data_out, err_drop
    );

    modport slave (
        input  mode_in, para_e, para_in, data_e, data_in,
`ifdef LAYER_POST_RES_EN
               res,
`endif
        output para_done, in_ready, data_e_out, data_out, err_drop
    );
endinterface

// File: rtl/layer_post_proc.sv
// Binary-ResNet layer post-processing: partial-sum add, BN, optional residual, RPReLU, saturation.
// Optional residual input is enabled by defining LAYER_POST_RES_EN.
module layer_post_proc #(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4,
    parameter int PS_WIDTH    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PARA_WIDTH  = 8,
    parameter int LANES       = 16,
    parameter int FRAC_BITS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    layer_post_proc_if.slave bus,
    output logic [1:0]       state_o
);
    localparam int NB     = CHANNEL_NUM / LANES;
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CH_W   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int PSS_W  = PS_WIDTH + $clog2(MACRO_NUM);
    localparam int PROD_W = PARA_WIDTH + PSS_W;
    localparam int BN_W   = ((PROD_W > DATA_WIDTH) ? PROD_W : DATA_WIDTH) + 2;
    localparam int X_W    = BN_W + 1;
    localparam int Y_W    = PARA_WIDTH + X_W;
    localparam int Z_W    = Y_W + 1;
    localparam int IN_W   = CHANNEL_NUM * MACRO_NUM * PS_WIDTH;
    localparam int OUT_W  = CHANNEL_NUM * DATA_WIDTH;
    localparam int D_MAX  = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int D_MIN  = -(2 ** (DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                         state_q;
    logic [BEAT_W-1:0]              beat_q;
    logic [1:0]                     drain_q;
    logic                           in_ready_q;
    logic                           data_e_out_q;
    logic                           err_drop_q;
    logic [OUT_W-1:0]               data_out_q;
    logic [IN_W-1:0]                in_buf_q;
`ifdef LAYER_POST_RES_EN
    logic [OUT_W-1:0]               res_buf_q;
`endif

    // Parameter RAM indexed [type][channel]: 0 bn_a, 1 bn_b, 2 gamma, 3 beta, 4 zeta.
    logic signed [PARA_WIDTH-1:0]   prm_q [5][CHANNEL_NUM];
    logic [2:0]                     ld_type_q;
    logic [CH_W-1:0]                ld_ch_q;
    logic                           ld_full_q;
    logic                           para_done_q;

    logic                           v1_q, v2_q;
    logic [BEAT_W-1:0]              beat1_q, beat2_q;
    logic signed [PSS_W-1:0]        ps1_q [LANES];
    logic signed [BN_W-1:0]         bn2_q [LANES];
    logic signed [DATA_WIDTH-1:0]   acc_q [CHANNEL_NUM];

    assign bus.para_done  = para_done_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.data_e_out = data_e_out_q;
    assign bus.data_out   = data_out_q;
    assign bus.err_drop   = err_drop_q;
    assign state_o        = state_q;

    function automatic logic [CH_W-1:0] ch_of(input logic [BEAT_W-1:0] b, input int l);
        return CH_W'(int'(b) * LANES + l);
    endfunction

    function automatic logic signed [PSS_W-1:0] s1_sum(input logic [IN_W-1:0] buf_v, input int c);
        logic signed [PSS_W-1:0] acc;
        acc = '0;
        for (int m = 0; m < MACRO_NUM; m++)
            acc = acc + PSS_W'($signed(buf_v[(c*MACRO_NUM+m)*PS_WIDTH +: PS_WIDTH]));
        return acc;
    endfunction

    function automatic logic signed [BN_W-1:0] s2_bn(input logic signed [PARA_WIDTH-1:0] a,
                                                     input logic signed [PARA_WIDTH-1:0] b,
                                                     input logic signed [PSS_W-1:0]      ps,
                                                     input logic signed [DATA_WIDTH-1:0] r);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(ps);
        return BN_W'(prod >>> FRAC_BITS) + BN_W'(b) + BN_W'(r);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] s3_act(input logic signed [BN_W-1:0]       bn,
                                                            input logic signed [PARA_WIDTH-1:0] g,
                                                            input logic signed [PARA_WIDTH-1:0] beta,
                                                            input logic signed [PARA_WIDTH-1:0] zeta);
        logic signed [X_W-1:0] x;
        logic signed [Y_W-1:0] bx;
        logic signed [Y_W-1:0] y;
        logic signed [Z_W-1:0] z;
        x  = X_W'(bn) - X_W'(g);
        bx = Y_W'(beta) * Y_W'(x);
        y  = x[X_W-1] ? (bx >>> FRAC_BITS) : Y_W'(x);
        z  = Z_W'(y) + Z_W'(zeta);
        if (z > Z_W'(D_MAX))      return DATA_WIDTH'(D_MAX);
        else if (z < Z_W'(D_MIN)) return DATA_WIDTH'(D_MIN);
        else                      return z[DATA_WIDTH-1:0];
    endfunction

    // Control FSM with registered handshake outputs; an abort never touches data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            drain_q      <= '0;
            in_ready_q   <= 1'b1;
            data_e_out_q <= 1'b0;
            err_drop_q   <= 1'b0;
            data_out_q   <= '0;
            in_buf_q     <= '0;
`ifdef LAYER_POST_RES_EN
            res_buf_q    <= '0;
`endif
        end else begin
            data_e_out_q <= 1'b0;
            if (bus.data_e && bus.mode_in && !in_ready_q)
                err_drop_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (bus.data_e && bus.mode_in) begin
                        in_buf_q   <= bus.data_in;
`ifdef LAYER_POST_RES_EN
                        res_buf_q  <= bus.res;
`endif
                        beat_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.mode_in) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (beat_q == BEAT_W'(NB - 1)) begin
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!bus.mode_in) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (drain_q == 2'd3) begin
                        for (int c = 0; c < CHANNEL_NUM; c++)
                            data_out_q[c*DATA_WIDTH +: DATA_WIDTH] <= acc_q[c];
                        data_e_out_q <= 1'b1;
                        in_ready_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Serial loader: type-major, channel-minor; locks after the last word until mode_in returns high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_type_q   <= '0;
            ld_ch_q     <= '0;
            ld_full_q   <= 1'b0;
            para_done_q <= 1'b0;
            for (int t = 0; t < 5; t++)
                for (int c = 0; c < CHANNEL_NUM; c++)
                    prm_q[t][c] <= '0;
        end else if (bus.mode_in) begin
            ld_type_q <= '0;
            ld_ch_q   <= '0;
            ld_full_q <= 1'b0;
        end else if (bus.para_e && !ld_full_q) begin
            prm_q[ld_type_q][ld_ch_q] <= bus.para_in;
            if (ld_type_q == 3'd0 && ld_ch_q == '0)
                para_done_q <= 1'b0;
            if (ld_ch_q == CH_W'(CHANNEL_NUM - 1)) begin
                ld_ch_q <= '0;
                if (ld_type_q == 3'd4) begin
                    ld_full_q   <= 1'b1;
                    para_done_q <= 1'b1;
                end else begin
                    ld_type_q <= ld_type_q + 3'd1;
                end
            end else begin
                ld_ch_q <= ld_ch_q + CH_W'(1);
            end
        end
    end

    // Three-stage lane pipe; mode_in low flushes the valids so an aborted frame leaves no writes behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            beat1_q <= '0;
            beat2_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                ps1_q[l] <= '0;
                bn2_q[l] <= '0;
            end
            for (int c = 0; c < CHANNEL_NUM; c++)
                acc_q[c] <= '0;
        end else begin
            v1_q    <= (state_q == S_RUN) && bus.mode_in;
            v2_q    <= v1_q && bus.mode_in;
            beat1_q <= beat_q;
            beat2_q <= beat1_q;
            for (int l = 0; l < LANES; l++) begin
                ps1_q[l] <= s1_sum(in_buf_q, int'(ch_of(beat_q, l)));
`ifdef LAYER_POST_RES_EN
                bn2_q[l] <= s2_bn(prm_q[0][ch_of(beat1_q, l)], prm_q[1][ch_of(beat1_q, l)], ps1_q[l],
                                  $signed(res_buf_q[int'(ch_of(beat1_q, l))*DATA_WIDTH +: DATA_WIDTH]));
`else
                bn2_q[l] <= s2_bn(prm_q[0][ch_of(beat1_q, l)], prm_q[1][ch_of(beat1_q, l)], ps1_q[l], '0);
`endif
                if (v2_q && bus.mode_in)
                    acc_q[ch_of(beat2_q, l)] <= s3_act(bn2_q[l], prm_q[2][ch_of(beat2_q, l)],
                                                       prm_q[3][ch_of(beat2_q, l)], prm_q[4][ch_of(beat2_q, l)]);
            end
        end
    end
endmodule

// File: tb/tb_layer_post_proc.sv
// Directed bench for layer_post_proc: loader, arithmetic corners, latency, drop/abort and reset behaviour.
module tb_layer_post_proc;
  localparam int CN   = 128;
  localparam int MN   = 4;
  localparam int PSW  = 4;
  localparam int DW   = 8;
  localparam int PW   = 8;
  localparam int LN   = 16;
  localparam int FB   = 4;
  localparam int W_IN = CN * MN * PSW;
  localparam int LAT  = 12;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  int n_chk = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  int tb_prm [5][CN];
  int res_val = 0;

  always #5 clk = ~clk;

  layer_post_proc_if #(.CHANNEL_NUM(CN), .MACRO_NUM(MN), .PS_WIDTH(PSW), .DATA_WIDTH(DW),
                       .PARA_WIDTH(PW)) bus ();

  layer_post_proc #(.CHANNEL_NUM(CN), .MACRO_NUM(MN), .PS_WIDTH(PSW), .DATA_WIDTH(DW),
                    .PARA_WIDTH(PW), .LANES(LN), .FRAC_BITS(FB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W_IN-1:0] fill_nib(input logic [3:0] n);
    logic [W_IN-1:0] r;
    for (int i = 0; i < W_IN / 4; i++) r[i*4 +: 4] = n;
    return r;
  endfunction

  function automatic int model(input int c, input logic [W_IN-1:0] din);
    int ps, bn, x, y, z;
    logic signed [PSW-1:0] p;
    ps = 0;
    for (int m = 0; m < MN; m++) begin
      p = din[(c*MN+m)*PSW +: PSW];
      ps += int'(p);
    end
    bn = ((tb_prm[0][c] * ps) >>> FB) + tb_prm[1][c] + res_val;
    x  = bn - tb_prm[2][c];
    y  = (x >= 0) ? x : ((tb_prm[3][c] * x) >>> FB);
    z  = y + tb_prm[4][c];
    if (z > 127) z = 127;
    else if (z < -128) z = -128;
    return z;
  endfunction

  task automatic push_const(input int v);
    for (int c = 0; c < CN; c++) exp_q.push_back(DW'(v));
  endtask

  task automatic push_model(input logic [W_IN-1:0] din);
    for (int c = 0; c < CN; c++) exp_q.push_back(DW'(model(c, din)));
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < CN; c++) begin
      logic [DW-1:0] o, e;
      o = bus.data_out[c*DW +: DW];
      e = exp_q.pop_front();
      check($sformatf("%s_ch%0d", tag, c), int'($signed(o)), int'($signed(e)));
    end
  endtask

  // idx_mode=1 loads idx%7 and exercises para_done plus one surplus write.
  task automatic load_params(input bit idx_mode, input int a, input int b, input int g,
                             input int be, input int z);
    for (int i = 0; i < 5 * CN; i++) begin
      int t, v;
      t = i / CN;
      if (idx_mode) v = i % 7;
      else v = (t == 0) ? a : (t == 1) ? b : (t == 2) ? g : (t == 3) ? be : z;
      tb_prm[t][i % CN] = v;
      bus.mode_in = 1'b0;
      bus.para_e  = 1'b1;
      bus.para_in = PW'(v);
      @(negedge clk);
      if (idx_mode && i == 0) check("para_done_clr", bus.para_done, 0);
      if (idx_mode && i == 5 * CN - 2) check("para_done_early", bus.para_done, 0);
    end
    check("para_done_set", bus.para_done, 1);
    if (idx_mode) begin
      bus.para_in = 8'd85;
      @(negedge clk);
      check("para_done_hold", bus.para_done, 1);
    end
    bus.para_e  = 1'b0;
    bus.mode_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input logic [W_IN-1:0] din, input string tag);
    int lat;
    bus.data_in = din;
    bus.mode_in = 1'b1;
    bus.data_e  = 1'b1;
    @(negedge clk);
    bus.data_e = 1'b0;
    check({tag, "_busy"}, bus.in_ready, 0);
    lat = 0;
    while (!bus.data_e_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_ready"}, bus.in_ready, 1);
    check_outputs(tag);
  endtask

  initial begin
    logic [W_IN-1:0] din;
    int lat, pulses, first_lat;

    rst          = 1'b1;
    bus.mode_in  = 1'b1;
    bus.para_e   = 1'b0;
    bus.para_in  = '0;
    bus.data_e   = 1'b0;
    bus.data_in  = '0;
`ifdef LAYER_POST_RES_EN
    bus.res      = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_done", bus.para_done, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_vout", bus.data_e_out, 0);
    check("rst_dout", int'(bus.data_out == '0), 1);
    check("rst_err", bus.err_drop, 0);
    check("rst_state", int'(state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    // BN scale 1.0, leak 0.5: ps=+4 -> 4, ps=-4 -> -2; issued back to back.
    load_params(1'b0, 16, 0, 0, 8, 0);
    push_const(4);
    run_vec(fill_nib(4'h1), "ps_p1");
    push_const(-2);
    run_vec(fill_nib(4'hF), "ps_m1");
    check("b2b_no_err", bus.err_drop, 0);

    // Per-channel parameters idx%7; channel 0 given a nonzero sum so a stray 641st write would show.
    load_params(1'b1, 0, 0, 0, 0, 0);
    for (int k = 0; k < W_IN / 32; k++) din[k*32 +: 32] = $urandom;
    din[15:0] = 16'h1111;
    push_model(din);
    run_vec(din, "idx7_rand");
    for (int k = 0; k < W_IN / 32; k++) din[k*32 +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
    push_model(din);
    run_vec(din, "idx7_rand2");

    load_params(1'b0, 127, 0, 0, 127, 0);
    push_const(127);
    run_vec(fill_nib(4'h7), "sat_hi");
    push_const(-128);
    run_vec(fill_nib(4'h8), "sat_lo");
`ifdef LAYER_POST_RES_EN
    for (int c = 0; c < CN; c++) bus.res[c*DW +: DW] = 8'd5;
    res_val = 5;
    push_const(5);
    run_vec(fill_nib(4'h0), "res_add");
    bus.res = '0;
    res_val = 0;
`endif

    // Second data_e three cycles into the frame carries different data and must be dropped.
    push_const(127);
    bus.data_in = fill_nib(4'h7);
    bus.data_e  = 1'b1;
    @(negedge clk);
    bus.data_e = 1'b0;
    repeat (2) @(negedge clk);
    bus.data_in = fill_nib(4'h8);
    bus.data_e  = 1'b1;
    @(negedge clk);
    bus.data_e = 1'b0;
    check("drop_err", bus.err_drop, 1);
    check("drop_busy", bus.in_ready, 0);
    lat = 3;
    pulses = 0;
    first_lat = -1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.data_e_out) begin
        pulses++;
        if (first_lat < 0) first_lat = lat;
      end
    end
    check("drop_pulses", pulses, 1);
    check("drop_lat", first_lat, LAT);
    check_outputs("drop_data");

    // Abort mid-frame: no strobe, previous result held, error flag untouched.
    bus.data_in = fill_nib(4'h8);
    bus.data_e  = 1'b1;
    @(negedge clk);
    bus.data_e = 1'b0;
    repeat (3) @(negedge clk);
    bus.mode_in = 1'b0;
    @(negedge clk);
    bus.mode_in = 1'b1;
    check("abort_ready", bus.in_ready, 1);
    check("abort_state", int'(state_dbg), 0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.data_e_out) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_err_sticky", bus.err_drop, 1);
    push_const(127);
    check_outputs("abort_hold");

    // Reset in the middle of a frame.
    bus.data_in = fill_nib(4'h1);
    bus.data_e  = 1'b1;
    @(negedge clk);
    bus.data_e = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_vout", bus.data_e_out, 0);
    check("mrst_dout", int'(bus.data_out == '0), 1);
    check("mrst_ready", bus.in_ready, 1);
    check("mrst_done", bus.para_done, 0);
    check("mrst_err", bus.err_drop, 0);
    check("mrst_state", int'(state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
